// File: rtl/mem_pkg.sv
// Shared types for the two-port burst memory arbiter.
// State encoding, port indices and a small one-hot helper.
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RD_CMD   = 2'd1,
        S_RD_DATA  = 2'd2,
        S_WR_BURST = 2'd3
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic logic [1:0] port_onehot(input logic idx);
        return (idx == PORT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, on a tie
// the port that did not win last time is chosen.
module rr_arb2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // one-hot grant from the request pair and the last winner
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == PORT0) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Burst arbiter sharing one memory port between the data
// cache (p0) and instruction cache (p1).
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int AW        = 26
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] p0_addr,
    input  logic [3:0]    p0_byte_en,
    input  logic          p0_read,
    input  logic          p0_write,
    input  logic [31:0]   p0_writedata,
    output logic [31:0]   p0_readdata,
    output logic          p0_readdata_valid,
    output logic          p0_waitrequest,

    input  logic [AW-1:0] p1_addr,
    input  logic [3:0]    p1_byte_en,
    input  logic          p1_read,
    input  logic          p1_write,
    input  logic [31:0]   p1_writedata,
    output logic [31:0]   p1_readdata,
    output logic          p1_readdata_valid,
    output logic          p1_waitrequest,

    output logic [AW-1:0] o_m_addr,
    output logic [3:0]    o_m_byte_en,
    output logic          o_m_read,
    output logic          o_m_write,
    output logic [31:0]   o_m_writedata,
    input  logic [31:0]   i_m_readdata,
    input  logic          i_m_readdata_valid,
    input  logic          i_m_waitrequest,

    output logic [1:0]    o_grant,
    output logic          o_err
);

    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          win_write;

    logic [AW-1:0] own_addr;
    logic [3:0]    own_be;
    logic          own_write;
    logic [31:0]   own_wdata;
    logic          stray;

    assign req = {p1_read | p1_write, p0_read | p0_write};

    rr_arb2 u_rr (
        .req  (req),
        .last (last_q),
        .gnt  (gnt)
    );

    // a write request wins over a simultaneous read
    assign win_write = gnt[1] ? p1_write : p0_write;

    assign own_addr  = owner_q ? p1_addr      : p0_addr;
    assign own_be    = owner_q ? p1_byte_en   : p0_byte_en;
    assign own_write = owner_q ? p1_write     : p0_write;
    assign own_wdata = owner_q ? p1_writedata : p0_writedata;

    // read beats are only legal while collecting a read burst
    assign stray = i_m_readdata_valid && (state_q != S_RD_DATA);

    // state, owner, round-robin history, beat count, error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= PORT0;
            last_q  <= PORT1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // next-state: grant in idle, then count beats to the end
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q | stray;
        unique case (state_q)
            S_IDLE: begin
                if (|gnt) begin
                    owner_d = gnt[1];
                    last_d  = gnt[1];
                    cnt_d   = '0;
                    state_d = win_write ? S_WR_BURST
                                        : S_RD_CMD;
                end
            end
            S_RD_CMD: begin
                if (!i_m_waitrequest)
                    state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (i_m_readdata_valid) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_WR_BURST: begin
                if (own_write && !i_m_waitrequest) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // outputs: the owner sees memory, the other port is stalled
    always_comb begin
        p0_readdata       = '0;
        p0_readdata_valid = 1'b0;
        p0_waitrequest    = 1'b1;
        p1_readdata       = '0;
        p1_readdata_valid = 1'b0;
        p1_waitrequest    = 1'b1;
        o_m_addr          = '0;
        o_m_byte_en       = '0;
        o_m_read          = 1'b0;
        o_m_write         = 1'b0;
        o_m_writedata     = '0;
        unique case (state_q)
            S_RD_CMD: begin
                o_m_read    = 1'b1;
                o_m_addr    = own_addr;
                o_m_byte_en = own_be;
                if (owner_q == PORT1)
                    p1_waitrequest = i_m_waitrequest;
                else
                    p0_waitrequest = i_m_waitrequest;
            end
            S_RD_DATA: begin
                if (owner_q == PORT1) begin
                    p1_readdata       = i_m_readdata;
                    p1_readdata_valid = i_m_readdata_valid;
                end else begin
                    p0_readdata       = i_m_readdata;
                    p0_readdata_valid = i_m_readdata_valid;
                end
            end
            S_WR_BURST: begin
                o_m_write     = own_write;
                o_m_addr      = own_addr;
                o_m_byte_en   = own_be;
                o_m_writedata = own_wdata;
                if (owner_q == PORT1)
                    p1_waitrequest = i_m_waitrequest;
                else
                    p0_waitrequest = i_m_waitrequest;
            end
            default: ;
        endcase
    end

    assign o_grant = (state_q == S_IDLE) ? 2'b00
                                         : port_onehot(owner_q);
    assign o_err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed bursts push
// expected grants, read beats and write beats into queues.
module tb_mem_arbiter;

    localparam int AW = 26;

    typedef struct {
        int          port;
        logic [31:0] data;
    } rd_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [3:0]    p0_byte_en = 4'hF;
    logic          p0_read = 1'b0;
    logic          p0_write = 1'b0;
    logic [31:0]   p0_writedata = '0;
    logic [31:0]   p0_readdata;
    logic          p0_readdata_valid;
    logic          p0_waitrequest;
    logic [AW-1:0] p1_addr = '0;
    logic [3:0]    p1_byte_en = 4'hF;
    logic          p1_read = 1'b0;
    logic          p1_write = 1'b0;
    logic [31:0]   p1_writedata = '0;
    logic [31:0]   p1_readdata;
    logic          p1_readdata_valid;
    logic          p1_waitrequest;
    logic [AW-1:0] o_m_addr;
    logic [3:0]    o_m_byte_en;
    logic          o_m_read;
    logic          o_m_write;
    logic [31:0]   o_m_writedata;
    logic [31:0]   i_m_readdata = '0;
    logic          i_m_readdata_valid = 1'b0;
    logic          i_m_waitrequest = 1'b1;
    logic [1:0]    o_grant;
    logic          o_err;

    int checks = 0;
    int failures = 0;

    rd_t        rd_q[$];
    wr_t        wr_q[$];
    logic [1:0] gnt_q[$];
    logic [1:0] prev_gnt = 2'b00;

    mem_arbiter #(.BURST_LEN(4), .AW(AW)) dut (
        .clk                (clk),
        .rst                (rst),
        .p0_addr            (p0_addr),
        .p0_byte_en         (p0_byte_en),
        .p0_read            (p0_read),
        .p0_write           (p0_write),
        .p0_writedata       (p0_writedata),
        .p0_readdata        (p0_readdata),
        .p0_readdata_valid  (p0_readdata_valid),
        .p0_waitrequest     (p0_waitrequest),
        .p1_addr            (p1_addr),
        .p1_byte_en         (p1_byte_en),
        .p1_read            (p1_read),
        .p1_write           (p1_write),
        .p1_writedata       (p1_writedata),
        .p1_readdata        (p1_readdata),
        .p1_readdata_valid  (p1_readdata_valid),
        .p1_waitrequest     (p1_waitrequest),
        .o_m_addr           (o_m_addr),
        .o_m_byte_en        (o_m_byte_en),
        .o_m_read           (o_m_read),
        .o_m_write          (o_m_write),
        .o_m_writedata      (o_m_writedata),
        .i_m_readdata       (i_m_readdata),
        .i_m_readdata_valid (i_m_readdata_valid),
        .i_m_waitrequest    (i_m_waitrequest),
        .o_grant            (o_grant),
        .o_err              (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h",
                     name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: pop and compare whenever the DUT shows an event
    always @(negedge clk) begin
        if (o_grant !== prev_gnt) begin
            checks++;
            if (gnt_q.size() == 0) begin
                failures++;
                $display("FAIL grant_unexpected: got %b",
                         o_grant);
            end else begin
                logic [1:0] eg;
                eg = gnt_q.pop_front();
                if (o_grant !== eg) begin
                    failures++;
                    $display("FAIL grant_seq: got %b want %b",
                             o_grant, eg);
                end
            end
            prev_gnt = o_grant;
        end
        for (int p = 0; p < 2; p++) begin
            logic       v;
            logic [31:0] d;
            v = (p == 0) ? p0_readdata_valid : p1_readdata_valid;
            d = (p == 0) ? p0_readdata : p1_readdata;
            if (v === 1'b1) begin
                checks++;
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_unexpected: port %0d data %0h",
                             p, d);
                end else begin
                    rd_t e;
                    e = rd_q.pop_front();
                    if (e.port != p || d !== e.data) begin
                        failures++;
                        $display("FAIL rd_beat: got p%0d %0h want p%0d %0h",
                                 p, d, e.port, e.data);
                    end
                end
            end
        end
        if (o_m_write === 1'b1 && i_m_waitrequest === 1'b0) begin
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: data %0h",
                         o_m_writedata);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                if (32'(o_m_addr) !== w.addr ||
                    o_m_writedata !== w.data) begin
                    failures++;
                    $display("FAIL wr_beat: got %0h@%0h want %0h@%0h",
                             o_m_writedata, o_m_addr,
                             w.data, w.addr);
                end
            end
        end
    end

    task automatic rd_burst(input int port,
                            input logic [31:0] addr,
                            input logic [31:0] base,
                            input int nwait,
                            input bit drop);
        logic [3:0] be;
        be = port ? p1_byte_en : p0_byte_en;
        gnt_q.push_back(port ? 2'b10 : 2'b01);
        gnt_q.push_back(2'b00);
        for (int i = 0; i < 4; i++)
            rd_q.push_back('{port, base + 32'(i)});
        i_m_waitrequest = 1'b1;
        step();
        chk("rd_cmd", 32'(o_m_read), 32'd1);
        chk("rd_no_wr", 32'(o_m_write), 32'd0);
        chk("rd_addr", 32'(o_m_addr), addr);
        chk("rd_be", 32'(o_m_byte_en), 32'(be));
        chk("rd_other_wait",
            32'(port ? p0_waitrequest : p1_waitrequest), 32'd1);
        if (drop) begin
            if (port == 1) p1_read = 1'b0;
            else p0_read = 1'b0;
        end
        repeat (nwait) begin
            chk("rd_own_stall",
                32'(port ? p1_waitrequest : p0_waitrequest), 32'd1);
            step();
        end
        i_m_waitrequest = 1'b0;
        #1;
        chk("rd_own_accept",
            32'(port ? p1_waitrequest : p0_waitrequest), 32'd0);
        step();
        i_m_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_m_readdata_valid = 1'b1;
            i_m_readdata = base + 32'(i);
            step();
        end
        i_m_readdata_valid = 1'b0;
        i_m_readdata = '0;
    endtask

    task automatic wr_burst(input int port,
                            input logic [31:0] addr,
                            input logic [31:0] base);
        gnt_q.push_back(port ? 2'b10 : 2'b01);
        gnt_q.push_back(2'b00);
        for (int i = 0; i < 4; i++)
            wr_q.push_back('{addr, base + 32'(i)});
        i_m_waitrequest = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            if (port == 1) p1_writedata = base + 32'(i);
            else p0_writedata = base + 32'(i);
            i_m_waitrequest = 1'b1;
            #1;
            chk("wr_cmd", 32'(o_m_write), 32'd1);
            chk("wr_no_rd", 32'(o_m_read), 32'd0);
            chk("wr_own_stall",
                32'(port ? p1_waitrequest : p0_waitrequest), 32'd1);
            chk("wr_other_wait",
                32'(port ? p0_waitrequest : p1_waitrequest), 32'd1);
            step();
            i_m_waitrequest = 1'b0;
            #1;
            chk("wr_own_accept",
                32'(port ? p1_waitrequest : p0_waitrequest), 32'd0);
            chk("wr_other_hold",
                32'(port ? p0_waitrequest : p1_waitrequest), 32'd1);
            step();
        end
        if (port == 1) begin
            p1_write = 1'b0;
            p1_read = 1'b0;
        end else begin
            p0_write = 1'b0;
            p0_read = 1'b0;
        end
        i_m_waitrequest = 1'b1;
    endtask

    initial begin
        // reset state
        repeat (3) step();
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_p0_wait", 32'(p0_waitrequest), 32'd1);
        chk("rst_p1_wait", 32'(p1_waitrequest), 32'd1);
        chk("rst_m_read", 32'(o_m_read), 32'd0);
        chk("rst_m_write", 32'(o_m_write), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        rst = 1'b1;
        step();
        chk("idle_m_read", 32'(o_m_read), 32'd0);

        // p0 read with two stall cycles, request dropped early
        p0_addr = 26'h100;
        p0_byte_en = 4'h3;
        p0_read = 1'b1;
        rd_burst(0, 32'h100, 32'hA0, 2, 1'b1);
        step();
        chk("idle_after_rd", 32'(o_grant), 32'd0);

        // tie from reset: grants alternate p0, p1, p0, p1
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        p0_addr = 26'h200;
        p1_addr = 26'h300;
        p0_byte_en = 4'hF;
        p1_byte_en = 4'hC;
        p0_read = 1'b1;
        p1_read = 1'b1;
        rd_burst(0, 32'h200, 32'hB0, 0, 1'b0);
        rd_burst(1, 32'h300, 32'hB4, 0, 1'b0);
        rd_burst(0, 32'h200, 32'hB8, 0, 1'b0);
        p0_read = 1'b0;
        rd_burst(1, 32'h300, 32'hBC, 1, 1'b1);
        step();

        // p1 write with toggling memory stall
        p1_addr = 26'h400;
        p1_write = 1'b1;
        wr_burst(1, 32'h400, 32'h11);
        step();

        // read and write together is a write
        p0_addr = 26'h480;
        p0_read = 1'b1;
        p0_write = 1'b1;
        wr_burst(0, 32'h480, 32'h21);
        step();

        // stray read beat in idle sets sticky error
        i_m_readdata = 32'hDEAD;
        i_m_readdata_valid = 1'b1;
        step();
        i_m_readdata_valid = 1'b0;
        i_m_readdata = '0;
        chk("err_set", 32'(o_err), 32'd1);
        repeat (3) step();
        chk("err_sticky", 32'(o_err), 32'd1);

        // reset mid-burst after two of four beats
        p0_addr = 26'h500;
        p0_read = 1'b1;
        gnt_q.push_back(2'b01);
        gnt_q.push_back(2'b00);
        rd_q.push_back('{0, 32'hE0});
        rd_q.push_back('{0, 32'hE1});
        step();
        i_m_waitrequest = 1'b0;
        step();
        i_m_waitrequest = 1'b1;
        for (int i = 0; i < 2; i++) begin
            i_m_readdata_valid = 1'b1;
            i_m_readdata = 32'hE0 + 32'(i);
            step();
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(o_grant), 32'd0);
        chk("mid_rst_p0_valid", 32'(p0_readdata_valid), 32'd0);
        chk("mid_rst_p0_data", p0_readdata, 32'd0);
        chk("mid_rst_p0_wait", 32'(p0_waitrequest), 32'd1);
        chk("mid_rst_p1_wait", 32'(p1_waitrequest), 32'd1);
        chk("mid_rst_m_read", 32'(o_m_read), 32'd0);
        chk("mid_rst_m_addr", 32'(o_m_addr), 32'd0);
        chk("mid_rst_err", 32'(o_err), 32'd0);
        p0_read = 1'b0;
        step();
        i_m_readdata_valid = 1'b0;
        i_m_readdata = '0;
        step();
        chk("rst_hold_err", 32'(o_err), 32'd0);
        rst = 1'b1;
        step();

        // fresh p1 read after reset
        p1_addr = 26'h600;
        p1_byte_en = 4'hF;
        p1_read = 1'b1;
        rd_burst(1, 32'h600, 32'hC0, 1, 1'b1);
        repeat (3) step();
        chk("post_err", 32'(o_err), 32'd0);

        chk("gnt_q_left", 32'(gnt_q.size()), 32'd0);
        chk("rd_q_left", 32'(rd_q.size()), 32'd0);
        chk("wr_q_left", 32'(wr_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4: words per granted transaction (cache line), power of two, 1..16.
REQ-002 SHALL have parameter AW, default 26: backing-memory address width.
REQ-003 SHALL have ports clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have ports rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports p0_addr / p1_addr, input, AW: requester address (p0 = data cache, p1 = instruction cache).
REQ-006 SHALL have ports p0_byte_en / p1_byte_en, input, 4: byte enables.
REQ-007 SHALL have ports p0_read / p1_read, input, 1: burst read request.
REQ-008 SHALL have ports p0_write / p1_write, input, 1: burst write request.
REQ-009 SHALL have ports p0_writedata / p1_writedata, input, 32: write beat data.
REQ-010 SHALL have ports p0_readdata / p1_readdata, output, 32: returned read data.
REQ-011 SHALL have ports p0_readdata_valid / p1_readdata_valid, output, 1: read beat valid.
REQ-012 SHALL have ports p0_waitrequest / p1_waitrequest, output, 1: command/beat not accepted.
REQ-013 SHALL have ports o_m_addr, output, AW; o_m_byte_en, output, 4; o_m_read, output, 1; o_m_write, output, 1; o_m_writedata, output, 32: memory command.
REQ-014 SHALL have ports i_m_readdata, input, 32; i_m_readdata_valid, input, 1; i_m_waitrequest, input, 1: memory response.
REQ-015 SHALL have ports o_grant, output, 2: one-hot current owner, 00 when idle.
REQ-016 SHALL have ports o_err, output, 1: sticky protocol-error flag.

Function
REQ-017 SHALL implement FSM states IDLE, RD_CMD, RD_DATA, WR_BURST.
REQ-018 In IDLE with any request, SHALL grant next cycle: single requester wins; both requesting, the port not granted last wins (round-robin); after reset port 0 wins first.
REQ-019 A port asserting read and write together SHALL be treated as a write.
REQ-020 Grant SHALL be held for the whole burst; the other port's waitrequest SHALL stay 1, readdata_valid 0.
REQ-021 In IDLE both waitrequest SHALL be 1 and o_m_read/o_m_write 0 (one-cycle arbitration latency).
REQ-022 RD_CMD SHALL drive o_m_read=1 with the owner's addr/byte_en and owner waitrequest = i_m_waitrequest; on !i_m_waitrequest, SHALL move to RD_DATA.
REQ-023 RD_DATA SHALL route i_m_readdata/i_m_readdata_valid combinationally to the owner only; after the BURST_LEN-th valid beat, SHALL return to IDLE on the next edge.
REQ-024 WR_BURST SHALL forward the owner's write/addr/byte_en/writedata with owner waitrequest = i_m_waitrequest; a beat counts when owner write=1 and !i_m_waitrequest; after BURST_LEN counted beats, SHALL go to IDLE.
REQ-025 Beat counter SHALL be clog2(BURST_LEN)+1 bits, cleared on entry to each burst, never wrapping mid-burst.
REQ-026 A read beat arriving in IDLE, RD_CMD or WR_BURST SHALL be dropped and set o_err until reset.
REQ-027 Owner deasserting its request mid-burst SHALL NOT abort the burst; the FSM waits for the remaining beats.
REQ-028 The last-grant record SHALL update only at grant time.

Reset
REQ-029 rst=0 at any time, including mid-burst, SHALL force IDLE, counter 0, last-grant=p1, o_grant=00, o_err=0, o_m_read=o_m_write=0, both waitrequest=1, readdata_valid=0, data outputs 0.
REQ-030 Reset release SHALL take effect at the first rising edge with rst=1.

Structure
REQ-031 State encoding and port-index constants SHALL live in the shared package mem_pkg.
REQ-032 Round-robin selection SHALL be the sub-module rr_arb2 (inputs req[1:0], last; output gnt one-hot); the rest is flat.

Verification
REQ-033 p0 read, BURST_LEN=4, memory waitrequest 1 for 2 cycles then data 0xA0..0xA3 -> p0 receives 4 valid beats in order, o_grant 01 then 00.
REQ-034 p0 and p1 read in the same cycle from reset -> p0 served first, p1 next; repeated twice -> grants alternate 01,10,01,10.
REQ-035 p1 write 4 beats 0x11..0x14 with i_m_waitrequest toggling -> memory sees exactly 4 writes in order, p0 waitrequest 1 throughout.
REQ-036 Stray i_m_readdata_valid in IDLE -> no port valid, o_err=1 and stays 1.
REQ-037 rst low after 2 of 4 read beats -> all outputs at reset values; a fresh p1 read completes normally.
